uart_tx_fc: RTL and testbench
=============================

UART_TX_FC -- requirements
Module: uart_tx_fc

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of entries in the transmit FIFO (power of two, 2..16).
REQ-002 SHALL have parameter DIV_W, default 16, meaning the width of the baud divisor.
REQ-003 SHALL have port specman_hclk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-004 SHALL have port hresetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port baud_div, input, DIV_W bits: each bit period lasts baud_div+1 clocks.
REQ-006 SHALL have port wr_en, input, 1 bit: host write strobe.
REQ-007 SHALL have port wr_data, input, 8 bits: byte to enqueue.
REQ-008 SHALL have port full, output, 1 bit: FIFO holds FIFO_DEPTH entries.
REQ-009 SHALL have port cts_n, input, 1 bit: clear-to-send, active-low, from the remote receiver.
REQ-010 SHALL have port txd, output, 1 bit: serial line, idle high.
REQ-011 SHALL have port tx_busy, output, 1 bit: a frame is in progress (state is not IDLE).

Function
REQ-012 FIFO SHALL enqueue wr_data on a clock where wr_en=1 and full=0.
REQ-013 On wr_en=1 with full=1, the byte SHALL be dropped with no state change, even if a pop occurs the same clock.
REQ-014 Read and write pointers SHALL wrap modulo FIFO_DEPTH; an extra pointer bit SHALL distinguish full from empty.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY (config only) and STOP.
REQ-016 IDLE->START SHALL occur when the FIFO is non-empty and sampled cts_n=0; the head is popped into a shift register on that transition.
REQ-017 A byte written into an empty FIFO SHALL drive txd low exactly 2 clocks after the write edge, provided cts_n=0.
REQ-018 Baud counter SHALL clear on entry to START, increment each clock, and raise a tick when it reaches baud_div, then clear.
REQ-019 Each state SHALL advance on a tick: START (txd=0) -> DATA.
REQ-020 DATA SHALL send 8 bits LSB first, one per tick-period, then go to PARITY or STOP.
REQ-021 STOP SHALL drive txd=1 for one bit period, then go to START if the FIFO is non-empty and cts_n=0, otherwise IDLE (back-to-back frames, no gap).
REQ-022 cts_n rising mid-frame SHALL NOT abort the frame; it only blocks the next START.
REQ-023 baud_div=0 SHALL give one clock per bit.
REQ-024 A baud_div change mid-frame SHALL take effect at the next tick comparison.
REQ-025 txd SHALL be a registered output.

Reset
REQ-026 hresetn low SHALL immediately force: state IDLE, txd=1, tx_busy=0, full=0, FIFO empty, baud counter 0.
REQ-027 Reset mid-frame SHALL abort the frame and discard all FIFO contents.

Configuration
REQ-028 Macro UART_TX_PARITY_EN defined: DATA->PARITY, which sends one even-parity bit (XOR of the 8 data bits) for one bit period, then goes to STOP.
REQ-029 Macro UART_TX_PARITY_EN undefined: the PARITY state and its logic SHALL be absent, and DATA SHALL go directly to STOP.

Verification
REQ-030 baud_div=3, cts_n=0, write 0xA5 -> txd reads 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks; 40 clocks total (44 with parity, parity bit=0).
REQ-031 cts_n=1, write 5 bytes 0x01..0x05 -> full=1 after the 4th write, 0x05 dropped; after cts_n=0, exactly 0x01..0x04 sent back-to-back, tx_busy continuously high.
REQ-032 Raise cts_n=1 during the DATA bit 3 of 0x3C, with a second byte queued -> 0x3C completes with STOP; txd stays 1 and tx_busy=0 until cts_n=0.
REQ-033 baud_div=0, write 0xFF -> frame lasts 10 clocks: one low clock then 9 high clocks.
REQ-034 Assert hresetn=0 during DATA of 0x55 with 2 bytes queued -> txd=1, tx_busy=0, full=0 asynchronously; no transmission after release.

Source files
------------

// File: rtl/uart_tx_fc.sv
// UART transmitter: byte FIFO, CTS flow control and 8N1 framing with a programmable baud divisor.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fc #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic             specman_hclk,
    input  logic             hresetn,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    output logic             full,
    input  logic             cts_n,
    output logic             txd,
    output logic             tx_busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic [7:0]       w_head;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_tick;
    logic             w_txd_next;
    logic [DIV_W-1:0] r_baud_cnt;
    logic [7:0]       r_shift;
    logic [2:0]       r_bit_idx;
    logic             r_txd;
`ifdef UART_TX_PARITY_EN
    logic             r_parity;
`endif

    // Equal pointers mean empty; equal indices with differing wrap bits mean full.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_push  = wr_en && !full;
    assign w_head  = r_mem[r_rd_ptr[PTR_W-1:0]];

    // NOTE: the storage array has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge specman_hclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= wr_data;
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge specman_hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
        end
    end

    // A live divisor lowered below the running count still ends the bit instead of wrapping.
    assign w_tick = (r_state != S_IDLE) && (r_baud_cnt >= baud_div);

    always_ff @(posedge specman_hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_baud_cnt <= '0;
        end else if (r_state == S_IDLE || w_tick) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge specman_hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_shift   <= '0;
            r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else if (w_pop) begin
            r_shift   <= w_head;
            r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= ^w_head;
`endif
        end else if (r_state == S_DATA && w_tick) begin
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
        end
    end

    always_ff @(posedge specman_hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !cts_n) begin
                    w_state_next = S_START;
                    w_pop        = 1'b1;
                end
            end
            S_START: begin
                if (w_tick) w_state_next = S_DATA;
            end
            S_DATA: begin
                if (w_tick && r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    w_state_next = S_PARITY;
`else
                    w_state_next = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_tick) w_state_next = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    if (!w_empty && !cts_n) begin
                        w_state_next = S_START;
                        w_pop        = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_txd_next = 1'b1;
        tx_busy    = (r_state != S_IDLE);
        case (r_state)
            S_START:  w_txd_next = 1'b0;
            S_DATA:   w_txd_next = r_shift[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_txd_next = r_parity;
`endif
            default:  w_txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge specman_hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_txd <= 1'b1;
        end else begin
            r_txd <= w_txd_next;
        end
    end

    assign txd = r_txd;

endmodule

// File: tb/tb_uart_tx_fc.sv
// Bench for uart_tx_fc: frame-level reference model compared every cycle, plus literal frame checks.
// Honours UART_TX_PARITY_EN when it is defined for the build.
module tb_uart_tx_fc;
    localparam int DEPTH = 4;
    localparam int DIV_W = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic             clk      = 1'b0;
    logic             hresetn  = 1'b0;
    logic             wr_en    = 1'b0;
    logic [7:0]       wr_data  = 8'h00;
    logic             cts_n    = 1'b1;
    logic [DIV_W-1:0] baud_div = DIV_W'(3);
    logic             full;
    logic             txd;
    logic             tx_busy;

    int n_vec  = 0;
    int n_miss = 0;

`ifdef UART_TX_PARITY_EN
    logic a5_exp [NB] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    logic a5_exp [NB] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif

    uart_tx_fc #(.FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .specman_hclk (clk),
        .hresetn      (hresetn),
        .baud_div     (baud_div),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .cts_n        (cts_n),
        .txd          (txd),
        .tx_busy      (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NB-1:0] frame_bits(input logic [7:0] b);
        logic [NB-1:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    // Reference model: a byte queue plus the frame in flight, timed by clocks elapsed since its start.
    byte unsigned  m_q[$];
    logic          m_active  = 1'b0;
    int            m_elapsed = 0;
    int            m_div     = 0;
    logic [NB-1:0] m_bits    = '1;
    logic          exp_txd   = 1'b1;
    logic          pre_full;
    logic          fend;
    logic          launch;
    byte unsigned  m_b;

    always @(posedge clk or negedge hresetn) begin
        if (!hresetn) begin
            m_q.delete();
            m_active  = 1'b0;
            m_elapsed = 0;
            exp_txd   = 1'b1;
        end else begin
            pre_full = (m_q.size() == DEPTH);
            fend     = m_active && (m_elapsed == NB * (m_div + 1) - 1);
            launch   = (!m_active || fend) && (m_q.size() != 0) && !cts_n;
            exp_txd  = m_active ? m_bits[m_elapsed / (m_div + 1)] : 1'b1;
            if (launch) begin
                m_b       = m_q.pop_front();
                m_bits    = frame_bits(m_b);
                m_div     = int'(baud_div);
                m_active  = 1'b1;
                m_elapsed = 0;
            end else if (fend) begin
                m_active = 1'b0;
            end else if (m_active) begin
                m_elapsed++;
            end
            if (wr_en && !pre_full) m_q.push_back(wr_data);
        end
    end

    always @(negedge clk) begin
        if (hresetn) begin
            check("txd", txd, exp_txd);
            check("tx_busy", tx_busy, m_active);
            check("full", full, m_q.size() == DEPTH);
        end
    end

    // Called on a negedge; the write edge is the following posedge and it returns on the next negedge.
    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        wr_en = 1'b0;
        cts_n = 1'b0;
        while ((m_active || m_q.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain_done", !(m_active || m_q.size() != 0), 1'b1);
        check("drain_busy", tx_busy, 1'b0);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        #1;
        check("rst_txd", txd, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_full", full, 1'b0);
        @(negedge clk);
        hresetn  = 1'b1;
        cts_n    = 1'b0;
        baud_div = DIV_W'(3);

        // 0xA5 at four clocks per bit
        @(negedge clk);
        write_byte(8'hA5);
        check("a5_pre_txd", txd, 1'b1);
        check("a5_pre_busy", tx_busy, 1'b0);
        for (int j = 1; j <= NB * 4 + 1; j++) begin
            @(negedge clk);
            if (j == 1) check("a5_busy_on", tx_busy, 1'b1);
            if (j == 1) check("a5_txd_still_idle", txd, 1'b1);
            if (j == 2) check("a5_start_low", txd, 1'b0);
            if (j >= 3 && (j - 3) % 4 == 0) check("a5_bit", txd, a5_exp[(j - 3) / 4]);
            if (j == NB * 4) check("a5_busy_last", tx_busy, 1'b1);
            if (j == NB * 4 + 1) check("a5_busy_off", tx_busy, 1'b0);
        end

        // 0xFF at one clock per bit
        baud_div = DIV_W'(0);
        write_byte(8'hFF);
        for (int j = 1; j <= NB + 1; j++) begin
            @(negedge clk);
            if (j == 2) check("ff_start", txd, 1'b0);
            if (j >= 3 && j <= 10) check("ff_data", txd, 1'b1);
            if (j == NB + 1) check("ff_stop", txd, 1'b1);
            if (j == NB) check("ff_busy_last", tx_busy, 1'b1);
            if (j == NB + 1) check("ff_busy_off", tx_busy, 1'b0);
        end

        // Fill while CTS is deasserted; the fifth byte must be dropped
        baud_div = DIV_W'(1);
        cts_n    = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            write_byte(8'(i));
            if (i == 3) check("fill_not_full", full, 1'b0);
            if (i >= 4) check("fill_full", full, 1'b1);
        end
        repeat (3) @(negedge clk);
        check("fill_held_busy", tx_busy, 1'b0);
        cts_n = 1'b0;
        n = 0;
        for (int t = 0; t < 5 && !tx_busy; t++) @(negedge clk);
        while (tx_busy && n < 400) begin
            n++;
            @(negedge clk);
        end
        check_int("fill_busy_run", n, 4 * NB * 2);
        repeat (10) @(negedge clk);
        check("fill_drop", tx_busy, 1'b0);

        // CTS rises during data bit 3 of 0x3C with 0x77 queued
        write_byte(8'h3C);
        write_byte(8'h77);
        repeat (8) @(negedge clk);
        check("cts_mid_busy", tx_busy, 1'b1);
        cts_n = 1'b1;
        repeat (NB * 2 - 8) @(negedge clk);
        check("cts_end_busy", tx_busy, 1'b0);
        check("cts_end_txd", txd, 1'b1);
        repeat (10) @(negedge clk);
        check("cts_hold_busy", tx_busy, 1'b0);
        check("cts_hold_txd", txd, 1'b1);
        drain();

        // Randomized segments, divisor changed only while idle
        for (int seg = 0; seg < 6; seg++) begin
            baud_div = DIV_W'($urandom_range(0, 3));
            for (int c = 0; c < 400; c++) begin
                wr_en   = ($urandom_range(0, 2) == 0);
                wr_data = 8'($urandom);
                if ($urandom_range(0, 19) == 0) cts_n = ~cts_n;
                @(negedge clk);
            end
            drain();
        end

        // Asynchronous reset during DATA of 0x55 with two bytes queued
        baud_div = DIV_W'(2);
        write_byte(8'h55);
        write_byte(8'h11);
        write_byte(8'h22);
        repeat (6) @(negedge clk);
        check("rst_mid_busy", tx_busy, 1'b1);
        check("rst_mid_txd", txd, 1'b0);
        #2 hresetn = 1'b0;
        #1;
        check("rst_async_txd", txd, 1'b1);
        check("rst_async_busy", tx_busy, 1'b0);
        check("rst_async_full", full, 1'b0);
        repeat (3) @(negedge clk);
        hresetn = 1'b1;
        repeat (60) @(negedge clk);
        check("rst_after_busy", tx_busy, 1'b0);
        check("rst_after_txd", txd, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
